axi_sram_slave: RTL

//  Responder end of the simplified AXI bus (AR/RD/AW/WD channels, no IDs, no bursts).

---
 rtl/axi_sram_slave.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_sram_slave.sv
// axi_sram_slave
//   Responder end of the simplified AXI bus (AR/RD/AW/WD channels, no IDs, no
//   bursts): a single-port, word-organised SRAM model. The read and write paths
//   are independent, and each handles one transaction at a time.
//
//   Optional feature macro: AXI_BRESP_EN
//     Adds the write-response channel s_b_valid/s_b_ready and a W_RESP state.
//
// Ports
//   aclk, arst                   clock (rising edge); async active-low reset
//   s_ar_addr/valid/size/ready   read address channel
//   s_rd_data/valid/ready        read data channel (full aligned word returned)
//   s_aw_addr/valid/size/ready   write address channel
//   s_wd_data/valid/ready        write data channel (byte lanes in natural place)
//   s_b_valid/ready              write response (AXI_BRESP_EN only)
//
// Read FSM
//   state  | meaning
//   R_IDLE | s_ar_ready high, waiting for an AR handshake
//   R_DATA | word fetched on first cycle, then held until the RD handshake
//
// Write FSM
//   state   | meaning
//   W_IDLE  | collecting AW and WD into holding registers
//   W_WRITE | both held; masked write to the memory on this edge
//   W_RESP  | s_b_valid high until the B handshake (AXI_BRESP_EN only)

module axi_sram_slave #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        aclk,
    input  logic        arst,
    input  logic [31:0] s_ar_addr,
    input  logic        s_ar_valid,
    input  logic [3:0]  s_ar_size,
    output logic        s_ar_ready,
    output logic [31:0] s_rd_data,
    output logic        s_rd_valid,
    input  logic        s_rd_ready,
    input  logic [31:0] s_aw_addr,
    input  logic        s_aw_valid,
    input  logic [3:0]  s_aw_size,
    output logic        s_aw_ready,
    input  logic [31:0] s_wd_data,
    input  logic        s_wd_valid,
`ifdef AXI_BRESP_EN
    output logic        s_b_valid,
    input  logic        s_b_ready,
`endif
    output logic        s_wd_ready
);

    localparam int IW = $clog2(DEPTH_WORDS);

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
`ifdef AXI_BRESP_EN
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_WRITE = 2'd1, W_RESP = 2'd2} w_state_t;
`else
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_WRITE = 2'd1} w_state_t;
`endif

    logic [31:0]   mem [DEPTH_WORDS];

    r_state_t      r_state;
    logic [IW-1:0] r_idx;

    w_state_t      w_state;
    logic          aw_held;
    logic          wd_held;
    logic [IW-1:0] w_idx;
    logic [3:0]    w_strb;
    logic [31:0]   w_data;

    logic [31:0]   ar_off;
    logic [31:0]   aw_off;
    logic [3:0]    aw_strb;
    logic          aw_hs;
    logic          wd_hs;
    logic          aw_have;
    logic          wd_have;

    // Size is irrelevant on reads (full word returned); the offset bits outside
    // the index window wrap away by design.
    logic          addr_unused;
    assign addr_unused = ^{s_ar_size, ar_off[31:IW+2], ar_off[1:0],
                           aw_off[31:IW+2], aw_off[1:0]};

    assign ar_off  = s_ar_addr - BASE_ADDR;
    assign aw_off  = s_aw_addr - BASE_ADDR;
    assign aw_hs   = s_aw_valid && s_aw_ready;
    assign wd_hs   = s_wd_valid && s_wd_ready;
    assign aw_have = aw_held || aw_hs;
    assign wd_have = wd_held || wd_hs;

    // Halfword lane comes from addr[1] only, so a misaligned a[0] is dropped.
    always_comb begin
        aw_strb = 4'b1111;
        case (s_aw_size)
            4'd0:    aw_strb = 4'b0001 << s_aw_addr[1:0];
            4'd1:    aw_strb = s_aw_addr[1] ? 4'b1100 : 4'b0011;
            default: aw_strb = 4'b1111;
        endcase
    end

    // Read FSM. A read sampling mem on the W_WRITE edge gets the old word,
    // since both updates are non-blocking on the same edge.
    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            r_state    <= R_IDLE;
            r_idx      <= '0;
            s_ar_ready <= 1'b0;
            s_rd_valid <= 1'b0;
            s_rd_data  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_ar_valid && s_ar_ready) begin
                        r_idx      <= ar_off[IW+1:2];
                        s_ar_ready <= 1'b0;
                        r_state    <= R_DATA;
                    end else begin
                        s_ar_ready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (!s_rd_valid) begin
                        s_rd_data  <= mem[r_idx];
                        s_rd_valid <= 1'b1;
                    end else if (s_rd_ready) begin
                        s_rd_valid <= 1'b0;
                        s_ar_ready <= 1'b1;
                        r_state    <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write FSM. Readies are registered and track the holding registers.
    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            w_state    <= W_IDLE;
            aw_held    <= 1'b0;
            wd_held    <= 1'b0;
            w_idx      <= '0;
            w_strb     <= '0;
            w_data     <= '0;
            s_aw_ready <= 1'b0;
            s_wd_ready <= 1'b0;
`ifdef AXI_BRESP_EN
            s_b_valid  <= 1'b0;
`endif
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_held <= 1'b1;
                        w_idx   <= aw_off[IW+1:2];
                        w_strb  <= aw_strb;
                    end
                    if (wd_hs) begin
                        wd_held <= 1'b1;
                        w_data  <= s_wd_data;
                    end
                    s_aw_ready <= !aw_have;
                    s_wd_ready <= !wd_have;
                    if (aw_have && wd_have)
                        w_state <= W_WRITE;
                end
                W_WRITE: begin
                    aw_held <= 1'b0;
                    wd_held <= 1'b0;
`ifdef AXI_BRESP_EN
                    s_b_valid  <= 1'b1;
                    w_state    <= W_RESP;
`else
                    s_aw_ready <= 1'b1;
                    s_wd_ready <= 1'b1;
                    w_state    <= W_IDLE;
`endif
                end
`ifdef AXI_BRESP_EN
                W_RESP: begin
                    if (s_b_valid && s_b_ready) begin
                        s_b_valid  <= 1'b0;
                        s_aw_ready <= 1'b1;
                        s_wd_ready <= 1'b1;
                        w_state    <= W_IDLE;
                    end
                end
`endif
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Storage array: not reset. The write is gated by w_state, which reset
    // forces to W_IDLE, so a reset mid-transaction never leaves a partial word.
    always_ff @(posedge aclk) begin
        if (w_state == W_WRITE) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b])
                    mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end

endmodule
